// File: rtl/nox_mtimer_if.sv
// rtl/nox_mtimer_if.sv - AXI4 slave channel types and channel bundle for the nox machine timer
package nox_mtimer_pkg;

  typedef struct packed {
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        buser;
    logic        bvalid;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        ruser;
    logic        rvalid;
  } s_axi_miso_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

interface nox_mtimer_if;
  import nox_mtimer_pkg::*;

  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  modport master (output axi_mosi, input axi_miso);
  modport slave  (input axi_mosi, output axi_miso);
endinterface

// File: rtl/nox_mtimer.sv
// rtl/nox_mtimer.sv - RISC-V machine timer (mtime/mtimecmp/msip) behind a single-beat AXI4 slave
module nox_mtimer
  import nox_mtimer_pkg::*;
#(
  parameter int PRESCALE     = 1,
  parameter int ID_WIDTH_CHK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso,
  output logic        timer_irq_o,
  output logic        sw_irq_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  function automatic logic is_mapped(input logic [4:0] off);
    return off inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  // timer state
  logic [7:0]  presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q, timer_irq_d;
  logic        sw_irq_q, sw_irq_d;

  // write channel state
  w_state_t    w_state_q, w_state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [7:0]  bid_q, bid_d;
  logic [4:0]  aw_off_q, aw_off_d;
  logic        aw_err_q, aw_err_d;

  // read channel state
  r_state_t    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic [7:0]  rid_q, rid_d;
  logic [4:0]  ar_off_q, ar_off_d;
  logic [7:0]  ar_len_q, ar_len_d;
  logic        ar_err_q, ar_err_d;
  logic [7:0]  r_beat_q, r_beat_d;

  logic        tick;
  logic        w_beat;
  logic        w_apply;
  logic [4:0]  rd_off;
  logic [31:0] rd_val;
  logic        ar_err_new;
  logic        unused_bits;

  assign tick       = (presc_q == PRESC_LAST);
  assign w_beat     = (w_state_q == W_DATA) && axi_mosi.wvalid && wready_q;
  assign w_apply    = w_beat && !aw_err_q;
  assign ar_err_new = !is_mapped(axi_mosi.araddr[4:0]) || (axi_mosi.arlen != 8'd0);

  // Only offset bits [4:0] are decoded; the rest of each address is ignored.
  assign unused_bits = ^{axi_mosi.awaddr[31:5], axi_mosi.araddr[31:5], 1'(ID_WIDTH_CHK)};

  // Register file: a software write to mtime replaces the tick for that cycle.
  always_comb begin
    presc_d    = tick ? 8'd0 : presc_q + 8'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (w_apply) begin
      case (aw_off_q)
        5'h00: mtime_d = {mtime_q[63:32],
                          merge_bytes(mtime_q[31:0], axi_mosi.wdata, axi_mosi.wstrb)};
        5'h04: mtime_d = {merge_bytes(mtime_q[63:32], axi_mosi.wdata, axi_mosi.wstrb),
                          mtime_q[31:0]};
        5'h08: mtimecmp_d = {mtimecmp_q[63:32],
                             merge_bytes(mtimecmp_q[31:0], axi_mosi.wdata, axi_mosi.wstrb)};
        5'h0C: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], axi_mosi.wdata, axi_mosi.wstrb),
                             mtimecmp_q[31:0]};
        5'h10: if (axi_mosi.wstrb[0]) msip_d = axi_mosi.wdata[0];
        default: ;
      endcase
    end
    timer_irq_d = (mtime_q >= mtimecmp_q);
    sw_irq_d    = msip_q;
  end

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    aw_off_d  = aw_off_q;
    aw_err_d  = aw_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi_mosi.awvalid && awready_q) begin
          w_state_d = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = axi_mosi.awid;
          aw_off_d  = axi_mosi.awaddr[4:0];
          aw_err_d  = !is_mapped(axi_mosi.awaddr[4:0]) || (axi_mosi.awlen != 8'd0);
        end
      end
      W_DATA: begin
        if (w_beat && axi_mosi.wlast) begin
          w_state_d = W_RESP;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = aw_err_q ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: begin
        if (axi_mosi.bready && bvalid_q) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read source: the AR address on acceptance, the latched offset for later beats.
  always_comb begin
    rd_off = (r_state_q == R_IDLE) ? axi_mosi.araddr[4:0] : ar_off_q;
    case (rd_off)
      5'h00:   rd_val = mtime_q[31:0];
      5'h04:   rd_val = mtime_q[63:32];
      5'h08:   rd_val = mtimecmp_q[31:0];
      5'h0C:   rd_val = mtimecmp_q[63:32];
      5'h10:   rd_val = {31'd0, msip_q};
      default: rd_val = 32'd0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    ar_off_d  = ar_off_q;
    ar_len_d  = ar_len_q;
    ar_err_d  = ar_err_q;
    r_beat_d  = r_beat_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi_mosi.arvalid && arready_q) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = axi_mosi.arid;
          ar_off_d  = axi_mosi.araddr[4:0];
          ar_len_d  = axi_mosi.arlen;
          ar_err_d  = ar_err_new;
          r_beat_d  = 8'd0;
          rdata_d   = ar_err_new ? 32'd0 : rd_val;
          rresp_d   = ar_err_new ? RESP_SLVERR : RESP_OKAY;
          rlast_d   = (axi_mosi.arlen == 8'd0);
        end
      end
      R_DATA: begin
        if (axi_mosi.rready && rvalid_q) begin
          if (r_beat_q == ar_len_q) begin
            r_state_d = R_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            rdata_d  = ar_err_q ? 32'd0 : rd_val;
            rlast_d  = ((r_beat_q + 8'd1) == ar_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= 8'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      sw_irq_q    <= 1'b0;
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      bid_q       <= 8'd0;
      aw_off_q    <= 5'd0;
      aw_err_q    <= 1'b0;
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      rresp_q     <= RESP_OKAY;
      rlast_q     <= 1'b0;
      rid_q       <= 8'd0;
      ar_off_q    <= 5'd0;
      ar_len_q    <= 8'd0;
      ar_err_q    <= 1'b0;
      r_beat_q    <= 8'd0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      sw_irq_q    <= sw_irq_d;
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
      aw_off_q    <= aw_off_d;
      aw_err_q    <= aw_err_d;
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      rid_q       <= rid_d;
      ar_off_q    <= ar_off_d;
      ar_len_q    <= ar_len_d;
      ar_err_q    <= ar_err_d;
      r_beat_q    <= r_beat_d;
    end
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = awready_q;
    axi_miso.wready  = wready_q;
    axi_miso.bvalid  = bvalid_q;
    axi_miso.bresp   = bresp_q;
    axi_miso.bid     = bid_q;
    axi_miso.arready = arready_q;
    axi_miso.rvalid  = rvalid_q;
    axi_miso.rdata   = rdata_q;
    axi_miso.rresp   = rresp_q;
    axi_miso.rlast   = rlast_q;
    axi_miso.rid     = rid_q;
  end

  assign timer_irq_o = timer_irq_q;
  assign sw_irq_o    = sw_irq_q;

endmodule

// File: tb/tb_nox_mtimer.sv
// tb/tb_nox_mtimer.sv - directed table and sequence bench for nox_mtimer
module tb_nox_mtimer;
  import nox_mtimer_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timer_irq;
  logic sw_irq;
  int   since_rst = 0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[10];

  nox_mtimer_if bus ();

  nox_mtimer #(.PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .axi_mosi   (bus.axi_mosi),
    .axi_miso   (bus.axi_miso),
    .timer_irq_o(timer_irq),
    .sw_irq_o   (sw_irq)
  );

  always #5 clk = ~clk;

  // With PRESCALE=1 this equals mtime until software writes mtime.
  always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.axi_mosi = '0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    logic hs;
    int   n = 0;
    bus.axi_mosi.awaddr  = addr;
    bus.axi_mosi.awlen   = len;
    bus.axi_mosi.awid    = id;
    bus.axi_mosi.awvalid = 1'b1;
    do begin
      hs = bus.axi_miso.awready;
      cyc();
      n++;
    end while (!hs && n < 50);
    bus.axi_mosi.awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic w_phase(input logic [31:0] data, input logic [3:0] strb, input logic last,
                         input int delay);
    logic hs;
    int   n = 0;
    cyc(delay);
    bus.axi_mosi.wdata  = data;
    bus.axi_mosi.wstrb  = strb;
    bus.axi_mosi.wlast  = last;
    bus.axi_mosi.wvalid = 1'b1;
    do begin
      hs = bus.axi_miso.wready;
      cyc();
      n++;
    end while (!hs && n < 50);
    bus.axi_mosi.wvalid = 1'b0;
    bus.axi_mosi.wlast  = 1'b0;
    check("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic b_phase(output logic [1:0] resp, output logic [7:0] id);
    logic hs;
    int   n = 0;
    bus.axi_mosi.bready = 1'b1;
    do begin
      hs   = bus.axi_miso.bvalid;
      resp = bus.axi_miso.bresp;
      id   = bus.axi_miso.bid;
      cyc();
      n++;
    end while (!hs && n < 50);
    bus.axi_mosi.bready = 1'b0;
    check("b_handshake", 64'(hs), 64'd1);
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id,
                          output int at);
    logic hs;
    int   n = 0;
    bus.axi_mosi.araddr  = addr;
    bus.axi_mosi.arlen   = len;
    bus.axi_mosi.arid    = id;
    bus.axi_mosi.arvalid = 1'b1;
    do begin
      hs = bus.axi_miso.arready;
      cyc();
      n++;
    end while (!hs && n < 50);
    at = since_rst;
    bus.axi_mosi.arvalid = 1'b0;
    check("ar_handshake", 64'(hs), 64'd1);
  endtask

  task automatic r_phase(output logic [31:0] data, output logic [1:0] resp, output logic last,
                         output logic [7:0] id);
    logic hs;
    int   n = 0;
    bus.axi_mosi.rready = 1'b1;
    do begin
      hs   = bus.axi_miso.rvalid;
      data = bus.axi_miso.rdata;
      resp = bus.axi_miso.rresp;
      last = bus.axi_miso.rlast;
      id   = bus.axi_miso.rid;
      cyc();
      n++;
    end while (!hs && n < 50);
    bus.axi_mosi.rready = 1'b0;
    check("r_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic [1:0] resp);
    logic [7:0] id;
    aw_phase(addr, 8'd0, 8'd0);
    w_phase(data, strb, 1'b1, 0);
    b_phase(resp, id);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                    output int at);
    logic       last;
    logic [7:0] id;
    ar_phase(addr, 8'd0, 8'h00, at);
    r_phase(data, resp, last, id);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  rsp;
    logic        lst;
    logic [7:0]  id;
    int          at;
    int          rise;
    int          s_e;

    vecs[0] = '{32'h08, 32'h12345678, 4'hF, RESP_OKAY,   32'h08, 32'h12345678, RESP_OKAY};
    vecs[1] = '{32'h08, 32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h08, 32'h12BB56DD, RESP_OKAY};
    vecs[2] = '{32'h0C, 32'hCAFEF00D, 4'hA, RESP_OKAY,   32'h0C, 32'hCAFFF0FF, RESP_OKAY};
    vecs[3] = '{32'h10, 32'hFFFFFFFF, 4'hF, RESP_OKAY,   32'h10, 32'h00000001, RESP_OKAY};
    vecs[4] = '{32'h10, 32'hFFFFFFFE, 4'h1, RESP_OKAY,   32'h10, 32'h00000000, RESP_OKAY};
    vecs[5] = '{32'h14, 32'h00000005, 4'hF, RESP_SLVERR, 32'h14, 32'h00000000, RESP_SLVERR};
    vecs[6] = '{32'h1C, 32'h00000007, 4'hF, RESP_SLVERR, 32'h18, 32'h00000000, RESP_SLVERR};
    vecs[7] = '{32'h28, 32'h00000000, 4'h3, RESP_OKAY,   32'h08, 32'h12BB0000, RESP_OKAY};
    vecs[8] = '{32'h10, 32'h00000001, 4'h0, RESP_OKAY,   32'h10, 32'h00000000, RESP_OKAY};
    vecs[9] = '{32'h0C, 32'h00000000, 4'h0, RESP_OKAY,   32'h0C, 32'hCAFFF0FF, RESP_OKAY};

    // reset state
    do_reset();
    check("rst_awready", 64'(bus.axi_miso.awready), 64'd1);
    check("rst_arready", 64'(bus.axi_miso.arready), 64'd1);
    check("rst_bvalid", 64'(bus.axi_miso.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.axi_miso.rvalid), 64'd0);
    check("rst_timer_irq", 64'(timer_irq), 64'd0);
    check("rst_sw_irq", 64'(sw_irq), 64'd0);
    check("rst_user", 64'({bus.axi_miso.ruser, bus.axi_miso.buser}), 64'd0);

    // free-running mtime read
    cyc(10);
    ar_phase(32'h0, 8'd0, 8'h3E, at);
    r_phase(d, rsp, lst, id);
    check("mtime_lo_count", 64'(d), 64'(at - 1));
    check("mtime_lo_rresp", 64'(rsp), 64'(RESP_OKAY));
    check("mtime_lo_rlast", 64'(lst), 64'd1);
    check("mtime_lo_rid", 64'(id), 64'h3E);

    // timer interrupt rises one cycle after mtime reaches 0x20
    do_reset();
    wr(32'h0C, 32'h0, 4'hF, rsp);
    wr(32'h08, 32'h20, 4'hF, rsp);
    check("cmp_setup_before_match", 64'(since_rst < 33), 64'd1);
    rise = 0;
    while (since_rst < 45) begin
      if (timer_irq && rise == 0) rise = since_rst;
      cyc();
    end
    check("timer_irq_rise_cycle", 64'(rise), 64'd33);
    aw_phase(32'h0C, 8'd0, 8'd0);
    w_phase(32'h1, 4'hF, 1'b1, 0);
    check("timer_irq_hold", 64'(timer_irq), 64'd1);
    cyc();
    check("timer_irq_fall", 64'(timer_irq), 64'd0);
    b_phase(rsp, id);

    // mtime wrap through 0xFFFF_FFFF_FFFF_FFFF
    wr(32'h04, 32'hFFFFFFFF, 4'hF, rsp);
    aw_phase(32'h00, 8'd0, 8'd0);
    w_phase(32'hFFFFFFFE, 4'hF, 1'b1, 0);
    s_e = since_rst;
    cyc();
    check("wrap_irq_fe", 64'(timer_irq), 64'd1);
    cyc();
    check("wrap_irq_ff", 64'(timer_irq), 64'd1);
    cyc();
    check("wrap_irq_zero", 64'(timer_irq), 64'd0);
    b_phase(rsp, id);
    rd(32'h04, d, rsp, at);
    check("wrap_hi", 64'(d), 64'd0);
    rd(32'h00, d, rsp, at);
    check("wrap_lo", 64'(d), 64'(at - s_e - 3));

    // software interrupt
    aw_phase(32'h10, 8'd0, 8'd0);
    w_phase(32'h1, 4'h1, 1'b1, 0);
    check("sw_irq_latency", 64'(sw_irq), 64'd0);
    cyc();
    check("sw_irq_set", 64'(sw_irq), 64'd1);
    b_phase(rsp, id);
    check("msip_bresp", 64'(rsp), 64'(RESP_OKAY));
    wr(32'h10, 32'h0, 4'hF, rsp);
    cyc();
    check("sw_irq_clear", 64'(sw_irq), 64'd0);

    // register table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
      check($sformatf("vec%0d_bresp", i), 64'(rsp), 64'(vecs[i].bresp));
      rd(vecs[i].raddr, d, rsp, at);
      check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].rdata));
      check($sformatf("vec%0d_rresp", i), 64'(rsp), 64'(vecs[i].rresp));
    end

    // unmapped write with delayed W, then a burst write
    aw_phase(32'h14, 8'd0, 8'hA5);
    w_phase(32'hDEADBEEF, 4'hF, 1'b1, 5);
    b_phase(rsp, id);
    check("unmapped_bresp", 64'(rsp), 64'(RESP_SLVERR));
    check("unmapped_bid", 64'(id), 64'hA5);
    aw_phase(32'h08, 8'd1, 8'h3C);
    w_phase(32'h0BAD0BAD, 4'hF, 1'b0, 0);
    w_phase(32'h0BAD0BAD, 4'hF, 1'b1, 2);
    b_phase(rsp, id);
    check("burst_w_bresp", 64'(rsp), 64'(RESP_SLVERR));
    check("burst_w_bid", 64'(id), 64'h3C);
    rd(32'h08, d, rsp, at);
    check("noside_cmp_lo", 64'(d), 64'h12BB0000);
    rd(32'h0C, d, rsp, at);
    check("noside_cmp_hi", 64'(d), 64'hCAFFF0FF);
    rd(32'h10, d, rsp, at);
    check("noside_msip", 64'(d), 64'd0);

    // 4-beat read burst with stalls
    begin
      int          beats = 0;
      int          n = 0;
      logic        stalled = 1'b0;
      logic        stab_ok = 1'b1;
      logic        beat_ok = 1'b1;
      logic        last_ok = 1'b1;
      logic [34:0] snap = '0;
      logic [34:0] cur;
      ar_phase(32'h00, 8'd3, 8'h5A, at);
      while (beats < 4 && n < 200) begin
        cur = {bus.axi_miso.rdata, bus.axi_miso.rresp, bus.axi_miso.rlast};
        if (bus.axi_miso.rvalid) begin
          if (!stalled) begin
            bus.axi_mosi.rready = 1'b0;
            snap = cur;
            stalled = 1'b1;
          end else begin
            if (cur !== snap) stab_ok = 1'b0;
            bus.axi_mosi.rready = 1'($urandom_range(0, 1));
            if (bus.axi_mosi.rready) begin
              if (bus.axi_miso.rresp !== RESP_SLVERR || bus.axi_miso.rdata !== 32'd0 ||
                  bus.axi_miso.rid !== 8'h5A) beat_ok = 1'b0;
              if (bus.axi_miso.rlast !== (beats == 3)) last_ok = 1'b0;
              beats++;
              stalled = 1'b0;
            end
          end
        end else begin
          bus.axi_mosi.rready = 1'b0;
        end
        cyc();
        n++;
      end
      bus.axi_mosi.rready = 1'b0;
      check("burst_r_beats", 64'(beats), 64'd4);
      check("burst_r_stable", 64'(stab_ok), 64'd1);
      check("burst_r_fields", 64'(beat_ok), 64'd1);
      check("burst_r_rlast", 64'(last_ok), 64'd1);
      check("burst_r_done", 64'(bus.axi_miso.rvalid), 64'd0);
    end

    // read and write of the same register in the same cycle
    wr(32'h08, 32'h11111111, 4'hF, rsp);
    aw_phase(32'h08, 8'd0, 8'h01);
    bus.axi_mosi.wdata   = 32'h22222222;
    bus.axi_mosi.wstrb   = 4'hF;
    bus.axi_mosi.wlast   = 1'b1;
    bus.axi_mosi.wvalid  = 1'b1;
    bus.axi_mosi.araddr  = 32'h08;
    bus.axi_mosi.arlen   = 8'd0;
    bus.axi_mosi.arid    = 8'h02;
    bus.axi_mosi.arvalid = 1'b1;
    check("same_cycle_ready", 64'({bus.axi_miso.wready, bus.axi_miso.arready}), 64'd3);
    cyc();
    bus.axi_mosi.wvalid  = 1'b0;
    bus.axi_mosi.arvalid = 1'b0;
    r_phase(d, rsp, lst, id);
    check("same_cycle_old_value", 64'(d), 64'h11111111);
    b_phase(rsp, id);
    rd(32'h08, d, rsp, at);
    check("same_cycle_new_value", 64'(d), 64'h22222222);

    // reset in the middle of a write and a read
    begin
      logic seen = 1'b0;
      aw_phase(32'h08, 8'd0, 8'h07);
      ar_phase(32'h00, 8'd0, 8'h09, at);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.axi_mosi.bready = 1'b1;
      bus.axi_mosi.rready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (bus.axi_miso.bvalid || bus.axi_miso.rvalid) seen = 1'b1;
        cyc();
      end
      bus.axi_mosi.bready = 1'b0;
      bus.axi_mosi.rready = 1'b0;
      check("midop_no_response", 64'(seen), 64'd0);
      check("midop_ready", 64'({bus.axi_miso.awready, bus.axi_miso.arready}), 64'd3);
      rd(32'h0C, d, rsp, at);
      check("midop_cmp_hi", 64'(d), 64'hFFFFFFFF);
      rd(32'h08, d, rsp, at);
      check("midop_cmp_lo", 64'(d), 64'hFFFFFFFF);
      check("midop_timer_irq", 64'(timer_irq), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
